// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM encoding
// and NZCV flag bit positions.
package alu_arb_pkg;

   localparam int OP_ADD = 0;
   localparam int OP_SUB = 1;
   localparam int OP_MUL = 2;
   localparam int OP_OR  = 3;
   localparam int OP_LSL = 4;
   localparam int OP_LSR = 5;
   localparam int OP_MAX = 5;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant; the requester that did not win last time has
// priority when both are valid.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   input  logic       accept_i,
   output logic [1:0] gnt_o,
   output logic       gnt_id_o
);

   logic last_q;

   always_comb begin
      gnt_id_o = 1'b0;
      if (req_i == 2'b11)
         gnt_id_o = ~last_q;
      else if (req_i[1])
         gnt_id_o = 1'b1;
      gnt_o = {req_i[1] & gnt_id_o, req_i[0] & ~gnt_id_o};
   end

   // Reset to 1 so requester 0 wins the first contested grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_q <= 1'b1;
      else if (accept_i)
         last_q <= gnt_id_o;
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters and keeps the
// architectural NZCV register. Optional ALU_ARB_OPCHECK_EN rejects opcodes > OP_MAX.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int OPW     = 4,
   parameter int ALU_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [OPW-1:0]   req0_op,
   input  logic             req0_set,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [OPW-1:0]   req1_op,
   input  logic             req1_set,
   output logic [WIDTH-1:0] alu_dat1,
   output logic [WIDTH-1:0] alu_dat2,
   output logic [OPW-1:0]   alu_control,
   output logic             alu_set,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_z,
   input  logic             alu_n,
   input  logic             alu_c,
   input  logic             alu_v,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic [3:0]       rsp_nzcv,
   output logic [3:0]       flags_nzcv,
`ifdef ALU_ARB_OPCHECK_EN
   output logic             rsp_err,
`endif
   output logic             busy
);

   localparam int            CW       = $clog2(ALU_LAT) + 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(ALU_LAT - 1);

   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] alu_dat1_q, alu_dat2_q;
   logic [OPW-1:0]   alu_ctl_q;
   logic             alu_set_q;
   logic             rsp_id_q;
   logic [WIDTH-1:0] rsp_result_q;
   logic [3:0]       rsp_nzcv_q, flags_q;
`ifdef ALU_ARB_OPCHECK_EN
   logic             rsp_err_q;
`endif

   logic             idle;
   logic [1:0]       gnt;
   logic             gnt_id, accept;
   logic [WIDTH-1:0] sel_a, sel_b;
   logic [OPW-1:0]   sel_op;
   logic             sel_set;
   logic [3:0]       nzcv_in;

   assign idle = (state_q == IDLE);

   rr_arb2 u_arb (
      .clk      (clk),
      .rst      (rst),
      .req_i    ({req1_valid, req0_valid}),
      .accept_i (accept),
      .gnt_o    (gnt),
      .gnt_id_o (gnt_id)
   );

   assign req0_ready = idle & gnt[0];
   assign req1_ready = idle & gnt[1];
   assign accept     = req0_ready | req1_ready;

   assign sel_a   = gnt_id ? req1_a   : req0_a;
   assign sel_b   = gnt_id ? req1_b   : req0_b;
   assign sel_op  = gnt_id ? req1_op  : req0_op;
   assign sel_set = gnt_id ? req1_set : req0_set;

   always_comb begin
      nzcv_in         = '0;
      nzcv_in[FLAG_N] = alu_n;
      nzcv_in[FLAG_Z] = alu_z;
      nzcv_in[FLAG_C] = alu_c;
      nzcv_in[FLAG_V] = alu_v;
   end

   // ALU operand registers are deliberately not cleared after use; they only
   // change on the next accepted request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         alu_dat1_q   <= '0;
         alu_dat2_q   <= '0;
         alu_ctl_q    <= '0;
         alu_set_q    <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_nzcv_q   <= '0;
         flags_q      <= '0;
`ifdef ALU_ARB_OPCHECK_EN
         rsp_err_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  rsp_id_q <= gnt_id;
`ifdef ALU_ARB_OPCHECK_EN
                  if (sel_op > OPW'(OP_MAX)) begin
                     rsp_result_q <= '0;
                     rsp_nzcv_q   <= '0;
                     rsp_err_q    <= 1'b1;
                     state_q      <= RESP;
                  end else
`endif
                  begin
                     alu_dat1_q <= sel_a;
                     alu_dat2_q <= sel_b;
                     alu_ctl_q  <= sel_op;
                     alu_set_q  <= sel_set;
                     cnt_q      <= CNT_INIT;
                     state_q    <= EXEC;
                  end
               end
            end
            EXEC: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CW'(1);
               end else begin
                  rsp_result_q <= alu_result;
                  rsp_nzcv_q   <= nzcv_in;
                  if (alu_set_q)
                     flags_q <= nzcv_in;
`ifdef ALU_ARB_OPCHECK_EN
                  rsp_err_q    <= 1'b0;
`endif
                  state_q      <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready)
                  state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign alu_dat1    = alu_dat1_q;
   assign alu_dat2    = alu_dat2_q;
   assign alu_control = alu_ctl_q;
   assign alu_set     = alu_set_q;
   assign rsp_valid   = (state_q == RESP);
   assign rsp_id      = rsp_id_q;
   assign rsp_result  = rsp_result_q;
   assign rsp_nzcv    = rsp_nzcv_q;
   assign flags_nzcv  = flags_q;
   assign busy        = ~idle;
`ifdef ALU_ARB_OPCHECK_EN
   assign rsp_err     = rsp_err_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance at ALU_LAT=1, one at ALU_LAT=3,
// each driven by a small behavioural ALU.
module tb_alu_arbiter;
   import alu_arb_pkg::*;

   localparam int W   = 32;
   localparam int OPW = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // instance with ALU_LAT=1
   logic           r0v, r0s, r0rdy, r1v, r1s, r1rdy;
   logic [W-1:0]   r0a, r0b, r1a, r1b;
   logic [OPW-1:0] r0op, r1op;
   logic [W-1:0]   ad1, ad2, ares, rres;
   logic [OPW-1:0] actl;
   logic           aset, an, az, ac, av;
   logic           rv, rr, rid, bsy;
   logic [3:0]     rnzcv, flags;
`ifdef ALU_ARB_OPCHECK_EN
   logic           rerr;
`endif

   // instance with ALU_LAT=3
   logic           q0v, q0s, q0rdy, q1v, q1s, q1rdy;
   logic [W-1:0]   q0a, q0b, q1a, q1b;
   logic [OPW-1:0] q0op, q1op;
   logic [W-1:0]   qd1, qd2, qres, qrres;
   logic [OPW-1:0] qctl;
   logic           qset, qn, qz, qc, qv;
   logic           qrv, qrr, qid, qbsy;
   logic [3:0]     qrnzcv, qflags;
`ifdef ALU_ARB_OPCHECK_EN
   logic           qerr;
`endif

   alu_arbiter #(.WIDTH(W), .OPW(OPW), .ALU_LAT(1)) u_dut (
      .clk(clk), .rst(rst),
      .req0_valid(r0v), .req0_ready(r0rdy), .req0_a(r0a), .req0_b(r0b), .req0_op(r0op), .req0_set(r0s),
      .req1_valid(r1v), .req1_ready(r1rdy), .req1_a(r1a), .req1_b(r1b), .req1_op(r1op), .req1_set(r1s),
      .alu_dat1(ad1), .alu_dat2(ad2), .alu_control(actl), .alu_set(aset),
      .alu_result(ares), .alu_z(az), .alu_n(an), .alu_c(ac), .alu_v(av),
      .rsp_valid(rv), .rsp_ready(rr), .rsp_id(rid), .rsp_result(rres), .rsp_nzcv(rnzcv),
      .flags_nzcv(flags),
`ifdef ALU_ARB_OPCHECK_EN
      .rsp_err(rerr),
`endif
      .busy(bsy)
   );

   alu_arbiter #(.WIDTH(W), .OPW(OPW), .ALU_LAT(3)) u_dut3 (
      .clk(clk), .rst(rst),
      .req0_valid(q0v), .req0_ready(q0rdy), .req0_a(q0a), .req0_b(q0b), .req0_op(q0op), .req0_set(q0s),
      .req1_valid(q1v), .req1_ready(q1rdy), .req1_a(q1a), .req1_b(q1b), .req1_op(q1op), .req1_set(q1s),
      .alu_dat1(qd1), .alu_dat2(qd2), .alu_control(qctl), .alu_set(qset),
      .alu_result(qres), .alu_z(qz), .alu_n(qn), .alu_c(qc), .alu_v(qv),
      .rsp_valid(qrv), .rsp_ready(qrr), .rsp_id(qid), .rsp_result(qrres), .rsp_nzcv(qrnzcv),
      .flags_nzcv(qflags),
`ifdef ALU_ARB_OPCHECK_EN
      .rsp_err(qerr),
`endif
      .busy(qbsy)
   );

   // Behavioural ALU; subtract reports C as borrow. Returns {N,Z,C,V,result}.
   function automatic logic [W+3:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [OPW-1:0] op);
      logic [W:0]   t;
      logic [W-1:0] r;
      logic         c, v;
      t = '0; r = '0; c = 1'b0; v = 1'b0;
      case (op)
         4'd0: begin
            t = {1'b0, a} + {1'b0, b};
            r = t[W-1:0];
            c = t[W];
            v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
         end
         4'd1: begin
            r = a - b;
            c = (a < b);
            v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
         end
         4'd2: r = a * b;
         4'd3: r = a | b;
         4'd4: r = a << b[4:0];
         4'd5: r = a >> b[4:0];
         default: r = '0;
      endcase
      return {r[W-1], (r == '0), c, v, r};
   endfunction

   always_comb {an, az, ac, av, ares} = alu_f(ad1, ad2, actl);
   always_comb {qn, qz, qc, qv, qres} = alu_f(qd1, qd2, qctl);

   int errs   = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      r0v = 0; r0s = 0; r0a = '0; r0b = '0; r0op = '0;
      r1v = 0; r1s = 0; r1a = '0; r1b = '0; r1op = '0;
      q0v = 0; q0s = 0; q0a = '0; q0b = '0; q0op = '0;
      q1v = 0; q1s = 0; q1a = '0; q1b = '0; q1op = '0;
      rr = 1'b1; qrr = 1'b1;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_rsp_valid", rv, 0);
      chk("rst_busy", bsy, 0);
      chk("rst_dat1", ad1, 0);
      chk("rst_flags", flags, 0);
      chk("rst_ready0", r0rdy, 0);
      rst = 1'b0;

      // single add with set, latency check
      @(negedge clk);
      r0v = 1; r0a = 4; r0b = 4; r0op = 4'd0; r0s = 1;
      #1;
      chk("t1_ready0", r0rdy, 1);
      chk("t1_ready1", r1rdy, 0);
      @(negedge clk);
      r0v = 0;
      chk("t1_dat1", ad1, 4);
      chk("t1_dat2", ad2, 4);
      chk("t1_ctl", actl, 0);
      chk("t1_alu_set", aset, 1);
      chk("t1_busy", bsy, 1);
      chk("t1_no_rsp_yet", rv, 0);
      @(negedge clk);
      chk("t1_rsp_valid", rv, 1);
      chk("t1_result", rres, 8);
      chk("t1_id", rid, 0);
      chk("t1_nzcv", rnzcv, 4'b0000);
      chk("t1_flags", flags, 4'b0000);
      @(negedge clk);
      chk("t1_done", rv, 0);
      chk("t1_idle", bsy, 0);

      // both valid: last winner was 0, so grants go 1,0,1,0
      r0v = 1; r0a = 4;   r0b = 4; r0op = 4'd1; r0s = 1;
      r1v = 1; r1a = 256; r1b = 4; r1op = 4'd5; r1s = 0;
      for (int k = 0; k < 4; k++) begin
         logic exp_id;
         exp_id = (k % 2 == 0);
         #1;
         chk("rr_ready0", r0rdy, !exp_id);
         chk("rr_ready1", r1rdy, exp_id);
         @(negedge clk);
         @(negedge clk);
         chk("rr_rsp_valid", rv, 1);
         chk("rr_id", rid, exp_id);
         chk("rr_result", rres, exp_id ? 16 : 0);
         chk("rr_nzcv", rnzcv, exp_id ? 4'b0000 : 4'b0100);
         chk("rr_flags", flags, (k == 0) ? 4'b0000 : 4'b0100);
         chk("rr_resp_no_ready", r0rdy | r1rdy, 0);
         @(negedge clk);
      end
      r0v = 0; r1v = 0;

      // response backpressure: rsp_ready low for 5 cycles while req0 waits
      r0v = 1; r0a = 32'hF0; r0b = 32'h0F; r0op = 4'd3; r0s = 0; rr = 0;
      #1;
      chk("bp_ready0", r0rdy, 1);
      @(negedge clk);
      @(negedge clk);
      repeat (5) begin
         chk("bp_rsp_valid", rv, 1);
         chk("bp_result", rres, 32'hFF);
         chk("bp_id", rid, 0);
         chk("bp_ready0_low", r0rdy, 0);
         @(negedge clk);
      end
      rr = 1;
      #1;
      chk("bp_ready0_resp", r0rdy, 0);
      @(negedge clk);
      #1;
      chk("bp_reaccept", r0rdy, 1);
      chk("bp_flags_kept", flags, 4'b0100);
      @(negedge clk);
      r0v = 0;
      @(negedge clk);
      chk("bp_second_result", rres, 32'hFF);
      @(negedge clk);

`ifdef ALU_ARB_OPCHECK_EN
      // illegal opcode bypasses EXEC
      r0v = 1; r0a = 1; r0b = 1; r0op = 4'd9; r0s = 1;
      #1;
      chk("oc_ready0", r0rdy, 1);
      @(negedge clk);
      r0v = 0;
      chk("oc_rsp_valid", rv, 1);
      chk("oc_err", rerr, 1);
      chk("oc_result", rres, 0);
      chk("oc_nzcv", rnzcv, 0);
      chk("oc_flags", flags, 4'b0100);
      @(negedge clk);
      chk("oc_done", rv, 0);
      r0v = 1; r0a = 1; r0b = 1; r0op = 4'd0; r0s = 0;
      @(negedge clk);
      r0v = 0;
      @(negedge clk);
      chk("oc_ok_err", rerr, 0);
      chk("oc_ok_result", rres, 2);
      @(negedge clk);
`endif

      // reset while in EXEC drops the transaction
      r0v = 1; r0a = 5; r0b = 6; r0op = 4'd0; r0s = 1;
      @(negedge clk);
      r0v = 0;
      chk("rx_busy", bsy, 1);
      #2 rst = 1;
      #1;
      chk("rx_busy_clr", bsy, 0);
      chk("rx_dat1_clr", ad1, 0);
      chk("rx_set_clr", aset, 0);
      chk("rx_flags_clr", flags, 0);
      chk("rx_rsp_valid", rv, 0);
      @(negedge clk);
      rst = 0;
      @(negedge clk);
      chk("rx_no_rsp", rv, 0);
      r0v = 1; r0a = 4;   r0b = 4; r0op = 4'd1; r0s = 1;
      r1v = 1; r1a = 256; r1b = 4; r1op = 4'd5; r1s = 0;
      #1;
      chk("rx_grant0", r0rdy, 1);
      chk("rx_grant1", r1rdy, 0);
      @(negedge clk);
      r0v = 0; r1v = 0;
      @(negedge clk);
      chk("rx_id", rid, 0);
      chk("rx_flags", flags, 4'b0100);
      @(negedge clk);

      // ALU_LAT=3: inputs held three cycles before capture
      q1v = 1; q1a = 4; q1b = 4; q1op = 4'd2; q1s = 0;
      #1;
      chk("l3_ready1", q1rdy, 1);
      @(negedge clk);
      q1v = 0;
      chk("l3_dat1_c1", qd1, 4);
      chk("l3_dat2_c1", qd2, 4);
      chk("l3_ctl_c1", qctl, 2);
      chk("l3_rsp_c1", qrv, 0);
      @(negedge clk);
      chk("l3_dat1_c2", qd1, 4);
      chk("l3_rsp_c2", qrv, 0);
      chk("l3_busy_c2", qbsy, 1);
      @(negedge clk);
      chk("l3_ctl_c3", qctl, 2);
      chk("l3_rsp_c3", qrv, 0);
      @(negedge clk);
      chk("l3_rsp_valid", qrv, 1);
      chk("l3_result", qrres, 16);
      chk("l3_id", qid, 1);
      chk("l3_flags", qflags, 0);
      @(negedge clk);
      chk("l3_done", qrv, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
